// File: rtl/pipeline_restoring_divider.sv
// Pipelined restoring divider: WIDTH/WIDTH -> quotient + remainder, unsigned (two's complement when DIV_SIGNED_EN is defined).
// Latency WIDTH+1 cycles (WIDTH+2 with DIV_SIGNED_EN); throughput one result per cycle, in issue order.
// No backpressure: in_valid is sampled every cycle and results cannot be stalled.
module pipeline_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef struct packed {
        logic             vld;
        logic             dbz;
`ifdef DIV_SIGNED_EN
        logic             q_neg;
        logic             r_neg;
`endif
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] den;
    } stage_t;

    // st[0] is the init stage; st[k] holds the state after quotient bit k.
    stage_t st [0:WIDTH];

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One shift/trial-subtract step; the borrow out of the WIDTH+1 bit subtract selects restore.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] den);
        logic [2*WIDTH:0] sh;
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] rem_n;
        logic [WIDTH-1:0] quo_n;
        sh    = {1'b0, rem, quo} << 1;
        trial = sh[2*WIDTH:WIDTH] - {1'b0, den};
        quo_n = sh[WIDTH-1:0];
        if (trial[WIDTH]) begin
            rem_n = sh[2*WIDTH-1:WIDTH];
        end else begin
            rem_n    = trial[WIDTH-1:0];
            quo_n[0] = 1'b1;
        end
        return {rem_n, quo_n};
    endfunction

`ifdef DIV_SIGNED_EN
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= WIDTH; k++) begin
                st[k] <= '0;
            end
        end else begin
            if (in_valid) begin
                st[0].vld   <= 1'b1;
                st[0].dbz   <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                st[0].q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                st[0].r_neg <= dividend[WIDTH-1];
`endif
                st[0].rem   <= '0;
                st[0].quo   <= a_mag;
                st[0].den   <= b_mag;
            end else begin
                st[0].vld   <= 1'b0;
            end
            // Data fields only move with a valid token; bubbles just clear the valid bit.
            for (int k = 1; k <= WIDTH; k++) begin
                if (st[k-1].vld) begin
                    st[k]                  <= st[k-1];
                    {st[k].rem, st[k].quo} <= div_step(st[k-1].rem, st[k-1].quo, st[k-1].den);
                end else begin
                    st[k].vld              <= 1'b0;
                end
            end
        end
    end

`ifdef DIV_SIGNED_EN
    logic             fix_vld;
    logic             fix_dbz;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    // Sign fix: quotient truncates toward zero, remainder follows the dividend; x/0 forces -1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fix_vld <= 1'b0;
            fix_dbz <= 1'b0;
            fix_quo <= '0;
            fix_rem <= '0;
        end else begin
            fix_vld <= st[WIDTH].vld;
            if (st[WIDTH].vld) begin
                fix_dbz <= st[WIDTH].dbz;
                fix_quo <= st[WIDTH].dbz ? '1 :
                           (st[WIDTH].q_neg ? -st[WIDTH].quo : st[WIDTH].quo);
                fix_rem <= st[WIDTH].r_neg ? -st[WIDTH].rem : st[WIDTH].rem;
            end
        end
    end

    assign out_valid   = fix_vld;
    assign quotient    = fix_quo;
    assign remainder   = fix_rem;
    assign div_by_zero = fix_dbz;
`else
    assign out_valid   = st[WIDTH].vld;
    assign quotient    = st[WIDTH].quo;
    assign remainder   = st[WIDTH].rem;
    assign div_by_zero = st[WIDTH].dbz;
`endif

endmodule

// File: tb/tb_pipeline_restoring_divider.sv
// Randomised and directed stimulus for pipeline_restoring_divider against a plain-arithmetic reference.
module tb_pipeline_restoring_divider;
    localparam int W     = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT   = W + 2;
`else
    localparam int LAT   = W + 1;
`endif
    localparam int DEPTH = 4096;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    pipeline_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Expected output schedule, indexed by the cycle in which the result must be visible.
    logic         exp_v [0:DEPTH-1];
    logic [W-1:0] exp_q [0:DEPTH-1];
    logic [W-1:0] exp_r [0:DEPTH-1];
    logic         exp_z [0:DEPTH-1];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        int sa, sb, sq, sr;
        z = (b == 0);
        q = '1;
        r = a;
        if (b != 0) begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            sq = sa / sb;
            sr = sa % sb;
`else
            sa = int'(a);
            sb = int'(b);
            sq = sa / sb;
            sr = sa % sb;
`endif
            q = sq[W-1:0];
            r = sr[W-1:0];
        end
    endfunction

    // Advance one clock and compare every output against the schedule / held values.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check("out_valid", out_valid, exp_v[cyc]);
        if (exp_v[cyc]) begin
            last_q = exp_q[cyc];
            last_r = exp_r[cyc];
            last_z = exp_z[cyc];
        end
        check("quotient", quotient, last_q);
        check("remainder", remainder, last_r);
        check("div_by_zero", div_by_zero, last_z);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic         z;
        ref_div(a, b, q, r, z);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        exp_v[cyc+LAT] = 1'b1;
        exp_q[cyc+LAT] = q;
        exp_r[cyc+LAT] = r;
        exp_z[cyc+LAT] = z;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_quotient", quotient, '0);
        check("arst_remainder", remainder, '0);
        check("arst_dbz", div_by_zero, 1'b0);
        for (int i = 1; i <= LAT + 1; i++) exp_v[cyc+i] = 1'b0;
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_v[i] = 1'b0;
            exp_q[i] = '0;
            exp_r[i] = '0;
            exp_z[i] = 1'b0;
        end
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_quotient", quotient, '0);
        check("reset_remainder", remainder, '0);
        check("reset_dbz", div_by_zero, 1'b0);
        step();
        rst_n = 1'b1;
        idle(2);

`ifndef DIV_SIGNED_EN
        // Single issue: result exactly LAT cycles later.
        issue(8'd200, 8'd7);
        idle(LAT - 1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_quotient", quotient, 8'd28);
        check("t1_remainder", remainder, 8'd4);
        idle(2);
        // Back-to-back issues.
        issue(8'd255, 8'd1);  issue(8'd5, 8'd9);    issue(8'd100, 8'd10); issue(8'd0, 8'd3);
        issue(8'd128, 8'd128); issue(8'd77, 8'd8);  issue(8'd1, 8'd255);  issue(8'd254, 8'd2);
        idle(LAT);
        // Divide by zero followed by a normal divide.
        issue(8'h55, 8'd0);
        issue(8'd9, 8'd3);
        idle(LAT - 2);
        check("t3_dbz_quotient", quotient, 8'hFF);
        check("t3_dbz_remainder", remainder, 8'h55);
        check("t3_dbz_flag", div_by_zero, 1'b1);
        idle(2);
        // Alternating bubbles.
        issue(8'd50, 8'd6);
        idle(1);
        issue(8'd13, 8'd13);
        idle(LAT + 1);
`else
        issue(8'hF9, 8'd2);
        idle(LAT - 1);
        check("s_m7_2_quotient", quotient, 8'hFD);
        check("s_m7_2_remainder", remainder, 8'hFF);
        issue(8'd7, 8'hFE);
        idle(LAT - 1);
        check("s_7_m2_quotient", quotient, 8'hFD);
        check("s_7_m2_remainder", remainder, 8'h01);
        issue(8'h80, 8'hFF);
        idle(LAT - 1);
        check("s_min_m1_quotient", quotient, 8'h80);
        check("s_min_m1_remainder", remainder, 8'h00);
        issue(8'hAB, 8'd0);
        issue(8'd50, 8'd6);
        idle(LAT);
`endif

        // Mid-flight reset discards everything in the pipe.
        issue(8'd90, 8'd7);
        issue(8'd91, 8'd3);
        issue(8'd92, 8'd5);
        pulse_reset();
        issue(8'd9, 8'd4);
        idle(LAT + 1);

        // Random traffic with bubbles, zero divisors and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 3));
                default: b = W'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else if ($urandom_range(0, 9) < 7) issue(a, b);
            else idle(1);
        end
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
